// File: rtl/bp_pkg.sv
// Shared types, constants and saturating-counter helpers for the branch predictor.
package bp_pkg;

    // Indexing modes selectable through the MODE parameter.
    localparam int MODE_BIMODAL = 0;
    localparam int MODE_GSHARE  = 1;

    // Widest counter supported; helpers operate at this width and callers truncate.
    localparam int CNT_MAX_W = 4;

    // SWEEP initialises the pattern table, READY is normal operation.
    typedef enum logic {
        SWEEP = 1'b0,
        READY = 1'b1
    } bpState_t;

    // Increment, holding at maxVal instead of wrapping.
    function automatic logic [CNT_MAX_W-1:0] sat_inc(input logic [CNT_MAX_W-1:0] cnt,
                                                     input logic [CNT_MAX_W-1:0] maxVal);
        return (cnt >= maxVal) ? maxVal : cnt + 1'b1;
    endfunction

    // Decrement, holding at zero instead of wrapping.
    function automatic logic [CNT_MAX_W-1:0] sat_dec(input logic [CNT_MAX_W-1:0] cnt);
        return (cnt == '0) ? '0 : cnt - 1'b1;
    endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: saturating counters with an asynchronous read port,
// one update write port, and a sweep write port driven by an internal pointer.
module bp_pht
    import bp_pkg::*;
#(
    parameter int ENTRIES  = 256,
    parameter int CNT_W    = 2,
    parameter int CNT_INIT = 1,
    parameter int IDX_W    = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sweepEn,
    input  logic [IDX_W-1:0] rdIdx,
    output logic [CNT_W-1:0] rdCnt,
    input  logic             updEn,
    input  logic [IDX_W-1:0] updIdx,
    input  logic             updTaken,
    output logic             sweepLast
);

    localparam logic [CNT_MAX_W-1:0] CNT_MAX = CNT_MAX_W'((1 << CNT_W) - 1);

    logic [CNT_W-1:0] pht [ENTRIES];
    logic [IDX_W-1:0] ptr;
    logic [CNT_MAX_W-1:0] updCur;
    logic [CNT_W-1:0] updCnt;

    // Lookup is combinational; a same-cycle update is not bypassed.
    assign rdCnt     = pht[rdIdx];
    assign sweepLast = (ptr == IDX_W'(ENTRIES - 1));

    assign updCur = CNT_MAX_W'(pht[updIdx]);
    assign updCnt = CNT_W'(updTaken ? sat_inc(updCur, CNT_MAX) : sat_dec(updCur));

    // Sweep pointer: parked at zero during reset, advances once per sweep cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            ptr <= '0;
        end else if (sweepEn) begin
            ptr <= ptr + 1'b1;
        end
    end

    // Table write: sweep initialisation, otherwise a resolved-branch counter update.
    always_ff @(posedge clk) begin
        // NOTE: the counter array has no reset; the sweep initialises it so it can map to RAM.
        if (sweepEn && !rst) begin
            pht[ptr] <= CNT_W'(CNT_INIT);
        end else if (updEn) begin
            pht[updIdx] <= updCnt;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Branch direction predictor: bimodal or gshare indexing into a saturating-counter
// table, speculative global history with mispredict repair, and a reset sweep FSM.
module branch_predictor
    import bp_pkg::*;
#(
    parameter  int ENTRIES  = 256,
    parameter  int CNT_W    = 2,
    parameter  int GHR_W    = 8,
    parameter  int MODE     = MODE_GSHARE,
    parameter  int CNT_INIT = 2 ** (CNT_W - 1) - 1,
    localparam int IDX_W    = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             pred_valid,
    input  logic [31:0]      pred_pc,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_idx,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic [GHR_W-1:0] upd_ghr,
    input  logic             upd_taken,
    input  logic             upd_mispredict,
    output logic             busy
);

    bpState_t         state;
    bpState_t         stateNext;
    logic [GHR_W-1:0] ghr;
    logic [IDX_W-1:0] pcIdx;
    logic [IDX_W-1:0] lookupIdx;
    logic [CNT_W-1:0] rdCnt;
    logic             sweepLast;
    logic             updEn;
    logic             specShift;
    logic             unusedPcBits;

    // Word-aligned PC bits outside the index window do not affect the prediction.
    assign unusedPcBits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0]};

    assign pcIdx     = pred_pc[IDX_W+1:2];
    assign lookupIdx = (MODE == MODE_GSHARE) ? (pcIdx ^ IDX_W'(ghr)) : pcIdx;

    assign pred_idx   = lookupIdx;
    assign pred_ghr   = ghr;
    assign pred_taken = busy ? 1'b0 : rdCnt[CNT_W-1];

    // Counters train only once the table holds valid data.
    assign updEn     = upd_valid && !busy;
    // A mispredict in E means the D-stage branch is wrong-path and must not shift history.
    assign specShift = pred_valid && !stall && !busy && !upd_mispredict;

    bp_pht #(
        .ENTRIES (ENTRIES),
        .CNT_W   (CNT_W),
        .CNT_INIT(CNT_INIT),
        .IDX_W   (IDX_W)
    ) u_pht (
        .clk      (clk),
        .rst      (rst),
        .sweepEn  (busy),
        .rdIdx    (lookupIdx),
        .rdCnt    (rdCnt),
        .updEn    (updEn),
        .updIdx   (upd_idx),
        .updTaken (upd_taken),
        .sweepLast(sweepLast)
    );

    // State register: reset always restarts the sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SWEEP;
        end else begin
            state <= stateNext;
        end
    end

    // Next state: leave SWEEP once the last entry is being written.
    always_comb begin
        // NOTE: default assignment first so no path leaves stateNext unassigned (no latch).
        stateNext = state;
        case (state)
            SWEEP:   if (sweepLast) stateNext = READY;
            READY:   stateNext = READY;
            default: stateNext = SWEEP;
        endcase
    end

    // FSM outputs: busy for the whole sweep.
    always_comb begin
        busy = (state == SWEEP);
    end

    // Global history: repair from the resolved branch wins over the speculative shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
        end else if (upd_valid && upd_mispredict) begin
            ghr <= GHR_W'({upd_ghr, upd_taken});
        end else if (specShift) begin
            ghr <= GHR_W'({ghr, pred_taken});
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: three instances (small bimodal for the
// sweep and collision, large bimodal for saturation, large gshare for history).
module tb_branch_predictor;
    import bp_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Small bimodal instance: ENTRIES=16, GHR_W=4.
    logic        stallS, predValidS, predTakenS, updValidS, updTakenS, updMispredictS, busyS;
    logic [31:0] predPcS;
    logic [3:0]  predIdxS, updIdxS, predGhrS, updGhrS;

    // Large bimodal instance: ENTRIES=256, GHR_W=8.
    logic        stallB, predValidB, predTakenB, updValidB, updTakenB, updMispredictB, busyB;
    logic [31:0] predPcB;
    logic [7:0]  predIdxB, updIdxB, predGhrB, updGhrB;

    // Default gshare instance: ENTRIES=256, GHR_W=8.
    logic        stallG, predValidG, predTakenG, updValidG, updTakenG, updMispredictG, busyG;
    logic [31:0] predPcG;
    logic [7:0]  predIdxG, updIdxG, predGhrG, updGhrG;

    branch_predictor #(.ENTRIES(16), .CNT_W(2), .GHR_W(4), .MODE(MODE_BIMODAL)) dutS (
        .clk(clk), .rst(rst), .stall(stallS), .pred_valid(predValidS), .pred_pc(predPcS),
        .pred_taken(predTakenS), .pred_idx(predIdxS), .pred_ghr(predGhrS),
        .upd_valid(updValidS), .upd_idx(updIdxS), .upd_ghr(updGhrS), .upd_taken(updTakenS),
        .upd_mispredict(updMispredictS), .busy(busyS)
    );

    branch_predictor #(.ENTRIES(256), .CNT_W(2), .GHR_W(8), .MODE(MODE_BIMODAL)) dutB (
        .clk(clk), .rst(rst), .stall(stallB), .pred_valid(predValidB), .pred_pc(predPcB),
        .pred_taken(predTakenB), .pred_idx(predIdxB), .pred_ghr(predGhrB),
        .upd_valid(updValidB), .upd_idx(updIdxB), .upd_ghr(updGhrB), .upd_taken(updTakenB),
        .upd_mispredict(updMispredictB), .busy(busyB)
    );

    branch_predictor dutG (
        .clk(clk), .rst(rst), .stall(stallG), .pred_valid(predValidG), .pred_pc(predPcG),
        .pred_taken(predTakenG), .pred_idx(predIdxG), .pred_ghr(predGhrG),
        .upd_valid(updValidG), .upd_idx(updIdxG), .upd_ghr(updGhrG), .upd_taken(updTakenG),
        .upd_mispredict(updMispredictG), .busy(busyG)
    );

    typedef struct {
        string       tag;
        logic [31:0] value;
    } expEntry_t;

    expEntry_t scoreboard[$];
    int nChecks = 0;
    int nPassed = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed === expected) nPassed++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    task automatic expectVal(input string tag, input logic [31:0] value);
        scoreboard.push_back('{tag: tag, value: value});
    endtask

    task automatic observe(input logic [31:0] observed);
        expEntry_t e;
        if (scoreboard.size() == 0) begin
            check("scoreboard_underflow", observed, ~observed);
        end else begin
            e = scoreboard.pop_front();
            check(e.tag, observed, e.value);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Saturation sequence on one counter starting at CNT_INIT=1, with expected MSB after each update.
    bit satDir [12] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
    bit satExp [12] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sweepCycles;
        int waitCycles;

        rst = 1'b1;
        {stallS, predValidS, updValidS, updTakenS, updMispredictS} = '0;
        {stallB, predValidB, updValidB, updTakenB, updMispredictB} = '0;
        {stallG, predValidG, updValidG, updTakenG, updMispredictG} = '0;
        predPcS = '0; updIdxS = '0; updGhrS = '0;
        predPcB = '0; updIdxB = '0; updGhrB = '0;
        predPcG = '0; updIdxG = '0; updGhrG = '0;

        // Reset held for three cycles.
        repeat (3) step();
        expectVal("rst_busy_s", 1);  observe(busyS);
        expectVal("rst_taken_s", 0); observe(predTakenS);
        expectVal("rst_busy_g", 1);  observe(busyG);
        expectVal("rst_ghr_g", 0);   observe(predGhrG);

        // Sweep on the 16-entry instance with taken updates hammering idx 2 (must be dropped).
        rst = 1'b0;
        predPcS = 32'h8;
        updValidS = 1'b1; updIdxS = 4'd2; updTakenS = 1'b1;
        #1;
        sweepCycles = 0;
        while (busyS && sweepCycles < 64) begin
            expectVal($sformatf("sweep_taken_%0d", sweepCycles), 0);
            observe(predTakenS);
            sweepCycles++;
            step();
        end
        updValidS = 1'b0;
        expectVal("sweep_busy_cycles", 16); observe(sweepCycles);

        // Every swept entry holds 1: MSB clear.
        for (int i = 0; i < 16; i++) begin
            predPcS = 32'(i) << 2;
            #1;
            expectVal($sformatf("init_taken_%0d", i), 0);
            observe(predTakenS);
        end

        // Same-index update and lookup: old counter this cycle, new one next cycle.
        predPcS = 32'h14;
        updValidS = 1'b1; updIdxS = 4'd5; updTakenS = 1'b1;
        #1;
        expectVal("collide_same_cycle", 0); observe(predTakenS);
        step();
        updValidS = 1'b0;
        #1;
        expectVal("collide_next_cycle", 1); observe(predTakenS);

        // One taken update on every other entry lifts 1 -> 2.
        for (int i = 0; i < 16; i++) begin
            if (i != 5) begin
                predPcS = 32'(i) << 2;
                updValidS = 1'b1; updIdxS = 4'(i); updTakenS = 1'b1;
                step();
                updValidS = 1'b0;
                #1;
                expectVal($sformatf("init_plus1_%0d", i), 1);
                observe(predTakenS);
            end
        end

        // Saturation on the 256-entry bimodal instance, pc 0x40 -> idx 16.
        waitCycles = 0;
        while (busyB && waitCycles < 1000) begin
            step();
            waitCycles++;
        end
        expectVal("bimodal_ready", 0); observe(busyB);
        predPcB = 32'h40;
        #1;
        expectVal("bimodal_idx", 16); observe(predIdxB);
        for (int i = 0; i < 12; i++) begin
            updValidB = 1'b1; updIdxB = 8'd16; updTakenB = satDir[i];
            expectVal($sformatf("sat_%0d", i), 32'(satExp[i]));
            step();
            updValidB = 1'b0;
            #1;
            observe(predTakenB);
        end

        // Gshare: load history 0xA5 through a repair, then hash with pc 0x400.
        waitCycles = 0;
        while (busyG && waitCycles < 1000) begin
            step();
            waitCycles++;
        end
        expectVal("gshare_ready", 0); observe(busyG);
        predPcG = 32'h400;
        updValidG = 1'b1; updMispredictG = 1'b1; updGhrG = 8'h52; updTakenG = 1'b1; updIdxG = 8'h77;
        step();
        {updValidG, updMispredictG, updTakenG} = '0;
        #1;
        expectVal("hash_ghr", 32'hA5);  observe(predGhrG);
        expectVal("hash_idx", 32'hA5);  observe(predIdxG);
        expectVal("hash_taken", 0);     observe(predTakenG);

        // One non-stalled predict of not-taken shifts a zero in.
        predValidG = 1'b1;
        step();
        stallG = 1'b1;
        #1;
        expectVal("spec_shift_ghr", 32'h4A); observe(predGhrG);

        // Stall holds history and prediction.
        for (int i = 0; i < 4; i++) begin
            step();
            expectVal($sformatf("stall_ghr_%0d", i), 32'h4A); observe(predGhrG);
            expectVal($sformatf("stall_taken_%0d", i), 0);    observe(predTakenG);
        end

        // Repair beats the concurrent D-stage shift.
        stallG = 1'b0;
        updValidG = 1'b1; updMispredictG = 1'b1; updGhrG = 8'h0F; updTakenG = 1'b1; updIdxG = 8'h77;
        step();
        {predValidG, updValidG, updMispredictG, updTakenG} = '0;
        #1;
        expectVal("repair_ghr", 32'h1F); observe(predGhrG);
        expectVal("repair_idx", 32'h1F); observe(predIdxG);

        check("scoreboard_drained", 32'(scoreboard.size()), 0);
        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch direction predictor for the 5-stage MIPS pipeline. It supplies `predictD` for the decode-stage branch and takes the resolved outcome from the execute stage (`branch_takeE`, `predict_wrong`). It replaces the fixed predict signal with a table of saturating counters indexed by PC, either directly (bimodal) or XORed with a speculative global history (gshare). The global history is repaired on a mispredict.

## Interface
- `ENTRIES`, 256: pattern-table entries; power of two, 16..4096; `IDX_W = log2(ENTRIES)`.
- `CNT_W`, 2: saturating counter width, 1..4.
- `GHR_W`, 8: global history length, 1..`IDX_W`.
- `MODE`, 1: 0 = bimodal, 1 = gshare.
- `CNT_INIT`, `2**(CNT_W-1)-1`: counter value after sweep (weakly not-taken).

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: pipeline D-stage stall (`stallD`); freezes speculative history.
- `pred_valid` in 1: branch in D this cycle (`branchD`).
- `pred_pc` in 32: `pcD`.
- `pred_taken` out 1: predicted direction.
- `pred_idx` out `IDX_W`: table index used; carried down the pipe with the branch.
- `pred_ghr` out `GHR_W`: history before this branch; carried down the pipe.
- `upd_valid` in 1: resolved branch in E (`branchE`, not flushed).
- `upd_idx` in `IDX_W`: carried `pred_idx`.
- `upd_ghr` in `GHR_W`: carried `pred_ghr`.
- `upd_taken` in 1: actual outcome (`branch_takeE`).
- `upd_mispredict` in 1: `predict_wrong & branchE`.
- `busy` out 1: table sweep in progress.

## Operation
- **Index**
  - Bimodal: `pred_pc[IDX_W+1:2]`.
  - Gshare: `pred_pc[IDX_W+1:2] ^ {zero-extend(ghr)}`.
- **Prediction:** `pred_taken` = MSB of `pht[idx]`. It is combinational from `pred_pc`, the current table and `ghr`.
- **Speculative history:** on `pred_valid & ~stall & ~busy & ~upd_mispredict`, `ghr <= {ghr[GHR_W-2:0], pred_taken}`.
- **Repair:** on `upd_valid & upd_mispredict`, `ghr <= {upd_ghr[GHR_W-2:0], upd_taken}`. Repair has priority over the speculative shift in the same cycle; the D-stage branch is wrong-path.
- **Counter update:** on `upd_valid & ~busy`, `pht[upd_idx]` increments if `upd_taken`, otherwise decrements. It saturates at `2**CNT_W-1` and at 0 (no wrap).
- **State machine:**
  - SWEEP: entered on `rst`. While `rst` is high, hold `ptr = 0`. After `rst` falls, write `CNT_INIT` to `pht[ptr]` and increment `ptr` each cycle. Leave to READY after writing `ENTRIES-1`.
  - READY: normal operation. Only `rst` returns to SWEEP.
- **During SWEEP:**
  - `busy = 1`, `pred_taken = 0`.
  - `pred_idx` and `pred_ghr` still driven.
  - Updates and history shifts are ignored.
  - `upd_mispredict` repair of `ghr` still applies.
- **`rst` asserted mid-sweep or mid-operation:** `ghr = 0`, `ptr = 0`, state SWEEP. Table contents are don't-care until swept.
- **Update and lookup on the same index, same cycle:** the lookup sees the old counter (no bypass).
- **`stall` high:** the prediction is still output. `ghr` is unchanged unless a repair occurs.

## Timing
- Reset values: `ghr = 0`, state SWEEP, `busy = 1`, `pred_taken = 0`.
- After the cycle `rst` deasserts, `busy` stays 1 for exactly `ENTRIES` cycles, then 0.
- Prediction latency is 0 cycles (same-cycle lookup).
- Counter and `ghr` updates are visible at the next edge.
- A mispredict repair at edge N is seen by the lookup in cycle N+1.
- Single clock domain; no handshake. The caller holds `pred_*` stable during `stall`.

## Structure
- Package `bp_pkg`: `MODE_BIMODAL`/`MODE_GSHARE` constants, the `sat_inc`/`sat_dec` functions, and the state enum (SWEEP, READY).
- One sub-module, `bp_pht`: counter array, asynchronous read port, saturating write port, and the sweep write port with `ptr`.
- Top level holds the FSM, `ghr`, and index hashing.
- Datapath wiring: `pred_idx`/`pred_ghr` go through the D→E `flopenrc` stage alongside `predictD`.

## Test plan
- Reset sweep: `ENTRIES=16`, `rst` high 3 cycles then low → `busy = 1` for exactly 16 cycles. During the sweep, `pred_taken = 0` and updates are dropped. Afterwards every entry reads `CNT_INIT = 1`.
- Saturation: bimodal, `pred_pc = 0x40`, 5 taken updates to idx 16 → counter 3, `pred_taken = 1`. 5 not-taken → counter 0, no wrap.
- Gshare hashing: `ghr = 8'hA5`, `pred_pc = 0x0000_0400` (`pc[9:2] = 0x00`) → `pred_idx = 0xA5` and `pred_ghr = 0xA5`. After one non-stalled predict with `pred_taken = 0`, `ghr = 0x4A`.
- Repair priority: same cycle `pred_valid = 1`, `upd_mispredict = 1`, `upd_ghr = 0x0F`, `upd_taken = 1` → next `ghr = 0x1F`, not shifted by the D branch.
- Stall: `stall = 1` for 4 cycles with `pred_valid = 1` → `ghr` unchanged, `pred_taken` stable.
- Same-index collision: update idx 5 taken (counter 1→2) while looking up idx 5 → this cycle `pred_taken = 0`, next cycle 1.
